// File: rtl/screen_pkg.sv
// screen_pkg: shared geometry, fill FSM states and Hack address helper for the screen framebuffer
package screen_pkg;
    localparam int SCREEN_ADDR_W = 13;
    localparam int SCREEN_DATA_W = 16;
    localparam int SCREEN_WORDS = 8192;
    localparam logic [15:0] SCREEN_BASE = 16'h4000;
    typedef enum logic {ST_IDLE, ST_FILL} fill_state_e;
    // Hack SCREEN byte-free address (0x4000-0x5FFF) to framebuffer word index
    function automatic logic [SCREEN_ADDR_W-1:0] screen_word(input logic [15:0] hack_addr);
        return SCREEN_ADDR_W'(hack_addr - SCREEN_BASE);
    endfunction
endpackage

// File: rtl/screen_mem_if.sv
// screen_mem_if: CPU, scan-out, fill and swap signals of the screen framebuffer
interface screen_mem_if;
    import screen_pkg::*;
    logic [SCREEN_ADDR_W-1:0] iCPU_ADDR, iVGA_ADDR;
    logic [SCREEN_DATA_W-1:0] iCPU_DATA, oCPU_DATA, oVGA_DATA, iFILL_DATA;
    logic iCPU_WE, iFILL, oBUSY, iVS, iSWAP, oFRONT;
    modport master (
        output iCPU_ADDR, iCPU_DATA, iCPU_WE, iVGA_ADDR, iFILL, iFILL_DATA, iVS, iSWAP,
        input oCPU_DATA, oVGA_DATA, oBUSY, oFRONT
    );
    modport slave (
        input iCPU_ADDR, iCPU_DATA, iCPU_WE, iVGA_ADDR, iFILL, iFILL_DATA, iVS, iSWAP,
        output oCPU_DATA, oVGA_DATA, oBUSY, oFRONT
    );
endinterface

// File: rtl/screen_ram.sv
// screen_ram: one synchronous write port, two asynchronous read ports, no reset on contents
module screen_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/screen_mem.sv
// screen_mem: Hack screen framebuffer with CPU port, scan-out port and whole-screen fill engine
// SCREEN_DOUBLE_BUFFER_EN adds a second bank swapped on the frame edge.
module screen_mem
    import screen_pkg::*;
#(
    parameter int   ADDR_W = $clog2(SCREEN_WORDS),
    parameter int   DATA_W = SCREEN_DATA_W,
    parameter logic VS_POL = 1'b0
) (
    input logic iCLK,
    input logic iRST,
    screen_mem_if.slave bus
);
    fill_state_e state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx, waddr;
    logic [DATA_W-1:0] pattern, pattern_nx, wdata;
    logic filling, we, vs_q, frame_edge;

    assign filling = state == ST_FILL;
    assign bus.oBUSY = filling;

    always_comb begin
        state_nx = filling ? (&ptr ? ST_IDLE : ST_FILL) : (bus.iFILL ? ST_FILL : ST_IDLE);
        ptr_nx = filling ? ptr + 1'b1 : '0;
        pattern_nx = (!filling && bus.iFILL) ? bus.iFILL_DATA : pattern;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= ST_IDLE;
            ptr <= '0;
            pattern <= '0;
            vs_q <= VS_POL;
        end else begin
            state <= state_nx;
            ptr <= ptr_nx;
            pattern <= pattern_nx;
            vs_q <= bus.iVS;
        end
    end

    // fill owns the write port; CPU writes while busy are simply lost
    assign we = !iRST && (filling || bus.iCPU_WE);
    assign waddr = filling ? ptr : bus.iCPU_ADDR;
    assign wdata = filling ? pattern : bus.iCPU_DATA;
    assign frame_edge = (bus.iVS == VS_POL) && (vs_q != VS_POL);

`ifdef SCREEN_DOUBLE_BUFFER_EN
    logic front, swap_pending, do_swap;
    logic [DATA_W-1:0] cpu_rd [2];
    logic [DATA_W-1:0] vga_rd [2];

    assign do_swap = frame_edge && swap_pending && !filling;

    // a request arriving on the edge cycle survives to the following edge
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            front <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            front <= front ^ do_swap;
            swap_pending <= bus.iSWAP || (swap_pending && !do_swap);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        screen_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
            .clk(iCLK),
            .we(we && (front != 1'(b))),
            .waddr(waddr),
            .wdata(wdata),
            .raddr_a(bus.iCPU_ADDR),
            .rdata_a(cpu_rd[b]),
            .raddr_b(bus.iVGA_ADDR),
            .rdata_b(vga_rd[b])
        );
    end

    assign bus.oCPU_DATA = cpu_rd[~front];
    assign bus.oVGA_DATA = vga_rd[front];
    assign bus.oFRONT = front;
`else
    logic unused_swap;

    screen_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk(iCLK),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr_a(bus.iCPU_ADDR),
        .rdata_a(bus.oCPU_DATA),
        .raddr_b(bus.iVGA_ADDR),
        .rdata_b(bus.oVGA_DATA)
    );

    assign bus.oFRONT = 1'b0;
    assign unused_swap = bus.iSWAP ^ frame_edge;
`endif
endmodule

// File: tb/tb_screen_mem.sv
// tb_screen_mem: vector table, fill sequences and randomized traffic against a word-array model
module tb_screen_mem;
    import screen_pkg::*;

    typedef struct {
        logic        we;
        logic [15:0] hack;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp;
    } vec_t;

    logic iCLK = 1'b0;
    logic iRST;
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] model [2][SCREEN_WORDS];
    bit known [2][SCREEN_WORDS];
    bit front_m = 1'b0;
    vec_t tbl [10];
    int busy_n;

    always #5 iCLK = ~iCLK;

    screen_mem_if bus ();
    screen_mem dut (.iCLK(iCLK), .iRST(iRST), .bus(bus));

    function automatic bit cpu_bank();
`ifdef SCREEN_DOUBLE_BUFFER_EN
        return !front_m;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic mwrite(input logic [12:0] a, input logic [15:0] d);
        model[cpu_bank()][a] = d;
        known[cpu_bank()][a] = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.iCPU_WE = 1'b0;
        bus.iFILL = 1'b0;
        bus.iSWAP = 1'b0;
    endtask

    task automatic sweep(input string name);
        int bad_c = 0;
        int bad_v = 0;
        for (int i = 0; i < SCREEN_WORDS; i++) begin
            bus.iCPU_ADDR = 13'(i);
            bus.iVGA_ADDR = 13'(i);
            @(negedge iCLK);
            if (bus.oCPU_DATA !== model[cpu_bank()][i]) bad_c++;
            if (known[front_m][i] && bus.oVGA_DATA !== model[front_m][i]) bad_v++;
        end
        check({name, " cpu words wrong"}, bad_c, 0);
        check({name, " vga words wrong"}, bad_v, 0);
    endtask

    task automatic vs_edge();
        bus.iVS = 1'b0;
        cyc();
        bus.iVS = 1'b1;
    endtask

    // rst_at < 0: run to completion; inject: dropped CPU write, ignored re-fill, partial-content probe
    task automatic run_fill(input logic [15:0] pat, input int rst_at, input bit inject, output int n);
        int n_wr;
        bus.iFILL = 1'b1;
        bus.iFILL_DATA = pat;
        cyc();
        bus.iFILL = 1'b0;
        n = 0;
        while (bus.oBUSY === 1'b1 && n < 9000) begin
            if (inject && n == 10) begin
                bus.iCPU_WE = 1'b1;
                bus.iCPU_ADDR = 13'h0100;
                bus.iCPU_DATA = 16'h1234;
            end
            if (inject && n == 20) begin
                bus.iFILL = 1'b1;
                bus.iFILL_DATA = ~pat;
            end
            if (inject && n == 50) begin
                bus.iCPU_ADDR = 13'h1FFF;
                bus.iVGA_ADDR = 13'd10;
                @(negedge iCLK);
                check("unfilled word mid-fill", bus.oCPU_DATA, model[cpu_bank()][13'h1FFF]);
`ifndef SCREEN_DOUBLE_BUFFER_EN
                check("scan-out filled word mid-fill", bus.oVGA_DATA, pat);
`endif
            end
            if (n == rst_at) iRST = 1'b1;
            cyc();
            idle_inputs();
            iRST = 1'b0;
            n++;
        end
        n_wr = (rst_at >= 0) ? rst_at : SCREEN_WORDS;
        for (int i = 0; i < n_wr; i++) mwrite(13'(i), pat);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 16'h4000, 16'hA5A5, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 16'h4000, 16'h0000, 1'b1, 16'hA5A5};
        tbl[2] = '{1'b1, 16'h5FFF, 16'h0001, 1'b0, 16'h0000};
        tbl[3] = '{1'b0, 16'h5FFF, 16'h0000, 1'b1, 16'h0001};
        tbl[4] = '{1'b1, 16'h4000, 16'h5A5A, 1'b1, 16'hA5A5};
        tbl[5] = '{1'b0, 16'h4000, 16'h0000, 1'b1, 16'h5A5A};
        tbl[6] = '{1'b1, 16'h4100, 16'hCAFE, 1'b0, 16'h0000};
        tbl[7] = '{1'b1, 16'h4100, 16'hBEEF, 1'b1, 16'hCAFE};
        tbl[8] = '{1'b0, 16'h4100, 16'h0000, 1'b1, 16'hBEEF};
        tbl[9] = '{1'b0, 16'h5FFF, 16'h0000, 1'b1, 16'h0001};
        iRST = 1'b1;
        idle_inputs();
        bus.iCPU_ADDR = '0;
        bus.iCPU_DATA = '0;
        bus.iVGA_ADDR = '0;
        bus.iFILL_DATA = '0;
        bus.iVS = 1'b1;
        repeat (3) cyc();
        check("reset busy", bus.oBUSY, 1'b0);
        check("reset front", bus.oFRONT, 1'b0);
        iRST = 1'b0;
        cyc();
        check("idle busy", bus.oBUSY, 1'b0);

        foreach (tbl[k]) begin
            logic [12:0] a;
            a = screen_word(tbl[k].hack);
            bus.iCPU_WE = tbl[k].we;
            bus.iCPU_ADDR = a;
            bus.iVGA_ADDR = a;
            bus.iCPU_DATA = tbl[k].wdata;
            @(negedge iCLK);
            if (tbl[k].chk) begin
                check($sformatf("vec%0d cpu read", k), bus.oCPU_DATA, tbl[k].exp);
                if (known[front_m][a]) check($sformatf("vec%0d vga read", k), bus.oVGA_DATA, model[front_m][a]);
            end
            cyc();
            if (tbl[k].we) mwrite(a, tbl[k].wdata);
        end
        idle_inputs();

        run_fill(16'hFFFF, -1, 1'b1, busy_n);
        check("fill busy cycles", busy_n, 8192);
        check("busy after fill", bus.oBUSY, 1'b0);
        bus.iCPU_ADDR = 13'h0100;
        @(negedge iCLK);
        check("dropped write word", bus.oCPU_DATA, 16'hFFFF);
        sweep("fill ffff");

        for (int k = 0; k < 400; k++) begin
            logic [12:0] a, va;
            logic w;
            logic [15:0] d;
            a = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom_range(8128, 8191));
            va = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 63)) : 13'($urandom_range(8128, 8191));
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            bus.iCPU_ADDR = a;
            bus.iVGA_ADDR = va;
            bus.iCPU_WE = w;
            bus.iCPU_DATA = d;
            @(negedge iCLK);
            check("rand cpu read", bus.oCPU_DATA, model[cpu_bank()][a]);
            if (known[front_m][va]) check("rand vga read", bus.oVGA_DATA, model[front_m][va]);
            cyc();
            if (w) mwrite(a, d);
        end
        idle_inputs();

        run_fill(16'h0000, 100, 1'b0, busy_n);
        check("reset-aborted busy cycles", busy_n, 101);
        check("busy after abort", bus.oBUSY, 1'b0);
        bus.iCPU_ADDR = 13'd99;
        @(negedge iCLK);
        check("last aborted-fill word", bus.oCPU_DATA, 16'h0000);
        bus.iCPU_ADDR = 13'd100;
        @(negedge iCLK);
        check("first unwritten word", bus.oCPU_DATA, 16'hFFFF);
        sweep("aborted fill");

`ifdef SCREEN_DOUBLE_BUFFER_EN
        bus.iSWAP = 1'b1;
        cyc();
        bus.iSWAP = 1'b0;
        vs_edge();
        front_m = 1'b1;
        check("front after first swap", bus.oFRONT, 1'b1);
        bus.iCPU_WE = 1'b1;
        bus.iCPU_ADDR = 13'd5;
        bus.iCPU_DATA = 16'hBEEF;
        cyc();
        mwrite(13'd5, 16'hBEEF);
        bus.iCPU_WE = 1'b0;
        bus.iSWAP = 1'b1;
        cyc();
        cyc();
        bus.iSWAP = 1'b0;
        bus.iVGA_ADDR = 13'd5;
        @(negedge iCLK);
        check("vga before edge", bus.oVGA_DATA, model[1][5]);
        check("front before edge", bus.oFRONT, 1'b1);
        cyc();
        vs_edge();
        front_m = 1'b0;
        @(negedge iCLK);
        check("front after edge", bus.oFRONT, 1'b0);
        check("vga after edge", bus.oVGA_DATA, 16'hBEEF);
        cyc();
        vs_edge();
        @(negedge iCLK);
        check("single toggle", bus.oFRONT, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
